// File: rtl/qualified_pipe_pkg.sv
// qualified_pipe_pkg: default widths, qualification constants and match helper
package qualified_pipe_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int STAGES_DEF = 2;
  localparam int CNT_W_DEF = 8;
  localparam logic [7:0] MATCH_MASK_DEF = 8'h0F;
  localparam logic [7:0] MATCH_VAL_DEF = 8'h0F;
  function automatic logic match_f(input logic [63:0] data, input logic [63:0] mask, input logic [63:0] val);
    return (data & mask) == val;
  endfunction
endpackage

// File: rtl/qualified_pipe_stage.sv
// pipe_stage: valid+payload register; payload loads only with a valid beat
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         src_v,
  input  logic [W-1:0] src_d,
  output logic         v_o,
  output logic [W-1:0] data_o
);
  logic         v_d, v_q;
  logic [W-1:0] data_d, data_q;
  always_comb begin
    v_d = clr ? 1'b0 : en ? src_v : v_q;
    data_d = (en & src_v) ? src_d : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      data_q <= '0;
    end else begin
      v_q <= v_d;
      data_q <= data_d;
    end
  end
  assign v_o = v_q;
  assign data_o = data_q;
endmodule

// File: rtl/qualified_pipe.sv
// qualified_pipe: mask/value-qualified valid/ready pipeline with saturating drop counter
module qualified_pipe
  import qualified_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter logic [DATA_W-1:0] MATCH_MASK = DATA_W'(MATCH_MASK_DEF),
  parameter logic [DATA_W-1:0] MATCH_VAL = DATA_W'(MATCH_VAL_DEF),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt
);
  logic [STAGES-1:0] v;
  logic [DATA_W-1:0] dat [STAGES];
  logic              acc, match;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  always_comb begin
    match = match_f(64'(in_data), 64'(MATCH_MASK), 64'(MATCH_VAL));
    in_ready = (out_ready | ~(&v)) & ~flush & ~rst;
    acc = in_valid & in_ready;
    cnt_d = (acc & ~match & ~(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // stage k may load when it is empty or every stage downstream of it can move
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic              en, sv;
    logic [DATA_W-1:0] sd;
    assign en = out_ready | ~(&v[STAGES-1:k]);
    if (k == 0) begin : g_head
      assign sv = acc & match;
      assign sd = in_data;
    end else begin : g_body
      assign sv = v[k-1];
      assign sd = dat[k-1];
    end
    pipe_stage #(.W(DATA_W)) u_stage (
      .clk(clk), .rst(rst), .clr(flush), .en(en),
      .src_v(sv), .src_d(sd), .v_o(v[k]), .data_o(dat[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign out_valid = v[STAGES-1];
  assign out_data = dat[STAGES-1];
  assign drop_cnt = cnt_q;
endmodule

// File: tb/tb_qualified_pipe.sv
// tb_qualified_pipe: directed checks of qualification, latency, backpressure, flush and reset
module tb_qualified_pipe;
  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  qualified_pipe #(.DATA_W(8), .STAGES(2), .MATCH_MASK(8'h0F), .MATCH_VAL(8'h0F), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 1, 0);
    repeat (3) tick;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    drive(0, 8'h00, 1, 0);
    check("post_rst_in_ready", 32'(in_ready), 1);

    drive(1, 8'hAF, 1, 0);
    check("stream_in_ready", 32'(in_ready), 1);
    tick;
    drive(1, 8'h3F, 1, 0);
    check("stream_not_early", 32'(out_valid), 0);
    tick;
    drive(1, 8'hFF, 1, 0);
    check("stream_v0", 32'(out_valid), 1);
    check("stream_d0", 32'(out_data), 32'hAF);
    tick;
    drive(0, 8'h00, 1, 0);
    check("stream_d1", 32'(out_data), 32'h3F);
    tick;
    drive(0, 8'h00, 1, 0);
    check("stream_d2", 32'(out_data), 32'hFF);
    tick;
    drive(0, 8'h00, 1, 0);
    check("stream_empty", 32'(out_valid), 0);
    check("stream_drop", 32'(drop_cnt), 0);

    drive(1, 8'h0E, 1, 0);
    tick;
    drive(1, 8'h1F, 1, 0);
    tick;
    drive(1, 8'hF0, 1, 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("drop_out_v", 32'(out_valid), 1);
    check("drop_out_d", 32'(out_data), 32'h1F);
    check("drop_cnt2", 32'(drop_cnt), 2);
    tick;
    drive(0, 8'h00, 1, 0);
    check("drop_only_one", 32'(out_valid), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'h00, 1, 0);
      tick;
    end
    drive(0, 8'h00, 1, 0);
    check("drop_sat", 32'(drop_cnt), 32'hF);
    check("drop_no_out", 32'(out_valid), 0);

    drive(1, 8'h0F, 0, 0);
    check("bp_rdy0", 32'(in_ready), 1);
    tick;
    drive(1, 8'h1F, 0, 0);
    check("bp_rdy1", 32'(in_ready), 1);
    tick;
    drive(1, 8'h2F, 0, 0);
    check("bp_full", 32'(in_ready), 0);
    check("bp_hold_v", 32'(out_valid), 1);
    check("bp_hold_d", 32'(out_data), 32'h0F);
    tick;
    drive(1, 8'h2F, 0, 0);
    check("bp_stable_d", 32'(out_data), 32'h0F);
    check("bp_still_full", 32'(in_ready), 0);
    tick;
    drive(1, 8'h2F, 1, 0);
    check("bp_pop_push", 32'(in_ready), 1);
    check("bp_out0", 32'(out_data), 32'h0F);
    tick;
    drive(0, 8'h00, 1, 0);
    check("bp_out1_v", 32'(out_valid), 1);
    check("bp_out1", 32'(out_data), 32'h1F);
    tick;
    drive(0, 8'h00, 1, 0);
    check("bp_out2_v", 32'(out_valid), 1);
    check("bp_out2", 32'(out_data), 32'h2F);
    tick;
    drive(0, 8'h00, 1, 0);
    check("bp_drained", 32'(out_valid), 0);
    check("bp_drop_kept", 32'(drop_cnt), 32'hF);

    drive(1, 8'h8F, 0, 0);
    tick;
    drive(1, 8'h9F, 0, 0);
    tick;
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    check("mrst_pre_v", 32'(out_valid), 1);
    tick;
    rst = 1'b0;
    drive(0, 8'h00, 1, 0);
    check("mrst_v", 32'(out_valid), 0);
    check("mrst_drop", 32'(drop_cnt), 0);
    check("mrst_d", 32'(out_data), 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("mrst_no_stale1", 32'(out_valid), 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("mrst_no_stale2", 32'(out_valid), 0);

    drive(1, 8'h6F, 0, 0);
    tick;
    drive(1, 8'h7F, 0, 0);
    tick;
    drive(1, 8'h5F, 1, 1);
    check("flush_pre_v", 32'(out_valid), 1);
    check("flush_in_ready", 32'(in_ready), 0);
    tick;
    drive(1, 8'h50, 1, 1);
    check("flush_v", 32'(out_valid), 0);
    check("flush_in_ready2", 32'(in_ready), 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("flush_no_accept", 32'(out_valid), 0);
    check("flush_drop", 32'(drop_cnt), 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("flush_no_5f", 32'(out_valid), 0);

    drive(1, 8'hCF, 1, 0);
    tick;
    drive(0, 8'h00, 1, 0);
    tick;
    drive(0, 8'h00, 1, 0);
    check("post_flush_v", 32'(out_valid), 1);
    check("post_flush_d", 32'(out_data), 32'hCF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
